// File: rtl/alu_pipe_if.sv
// Request/result bus of alu_pipe: valid/ready operation port in, valid/ready result port out.
// slave is the ALU side; master is the producer/consumer side.
interface alu_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic             neg;
  logic             busy;

  modport slave (
    input  in_valid, in1, in2, op, out_ready,
    output in_ready, out_valid, out, zero, carry, neg, busy
  );

  modport master (
    output in_valid, in1, in2, op, out_ready,
    input  in_ready, out_valid, out, zero, carry, neg, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and zero/carry/neg flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 110); otherwise 110 acts as 111.
//
// state | meaning
// IDLE  | waiting for a request
// EXEC  | multiplier iterating, one in2 bit per cycle (ALU_MUL_EN only)
// DONE  | holding the result until out_ready
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, EXEC = 2'd2} state_t;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             carry_q;
  logic             neg_q;
  logic             valid_q;
  logic             accept;

  logic [SHW-1:0]   sh;
  logic             sh_big;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH-1:0] res;
  logic             res_c;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;
  logic               busy_q;

  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign bus.busy = busy_q;
`else
  assign bus.busy = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = valid_q;
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.neg       = neg_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // in2 < WIDTH fits in SHW bits, so the low bits are the exact amount when not out of range
  assign sh     = bus.in2[SHW-1:0];
  assign sh_big = (bus.in2 >= W_LIM);

  always_comb begin
    add_w = {1'b0, bus.in1} + {1'b0, bus.in2};
    shl_w = {1'b0, bus.in1} << sh;
    shr_w = {bus.in1, 1'b0} >> sh;
    res   = '0;
    res_c = 1'b0;
    case (bus.op)
      3'b000: {res_c, res} = add_w;
      3'b001: begin
        res   = bus.in1 - bus.in2;
        res_c = (bus.in1 < bus.in2);
      end
      3'b010: res = bus.in1 & bus.in2;
      3'b011: res = bus.in1 ^ bus.in2;
      3'b100: if (!sh_big) {res_c, res} = shl_w;
      3'b101: if (!sh_big) {res, res_c} = shr_w;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      out_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (bus.op == 3'b110) begin
              state   <= EXEC;
              valid_q <= 1'b0;
              busy_q  <= 1'b1;
              cnt     <= '0;
              acc     <= '0;
              mcand   <= {{WIDTH{1'b0}}, bus.in1};
              mplier  <= bus.in2;
            end else
`endif
            begin
              state   <= DONE;
              valid_q <= 1'b1;
              out_q   <= res;
              carry_q <= res_c;
              zero_q  <= (res == '0);
              neg_q   <= res[WIDTH-1];
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        EXEC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (cnt == CNT_LAST) begin
            state   <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            out_q   <= acc_nxt[WIDTH-1:0];
            carry_q <= |acc_nxt[2*WIDTH-1:WIDTH];
            zero_q  <= (acc_nxt[WIDTH-1:0] == '0);
            neg_q   <= acc_nxt[WIDTH-1];
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8; expectations follow ALU_MUL_EN when it is defined.
module tb_alu_pipe;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] o;
    logic       c;
    logic       z;
    logic       n;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] o;
    logic       c;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[10];

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] o, input logic c);
    exp_t r;
    r.o = o;
    r.c = c;
    r.z = (o == 8'h00);
    r.n = o[7];
    return r;
  endfunction

  function automatic exp_t model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] w;
    logic [7:0]  ro;
    logic        rc;
    ro = 8'h00;
    rc = 1'b0;
    case (o)
      3'd0: begin w = 16'(a) + 16'(b); ro = w[7:0]; rc = w[8]; end
      3'd1: begin ro = a - b; rc = (a < b); end
      3'd2: ro = a & b;
      3'd3: ro = a ^ b;
      3'd4: if (b == 0) ro = a;
            else if (b < 8) begin w = 16'(a) << b; ro = w[7:0]; rc = w[8]; end
      3'd5: if (b == 0) ro = a;
            else if (b < 8) begin ro = a >> b; rc = a[b-1]; end
      3'd6: if (MUL_EN) begin w = 16'(a) * 16'(b); ro = w[7:0]; rc = |w[15:8]; end
      default: ;
    endcase
    return mk(ro, rc);
  endfunction

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input exp_t e);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.op  = o;
    bus.in1 = a;
    bus.in2 = b;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    sb.push_back(e);
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'(bus.out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_out",   32'(bus.out),   32'(mon_e.o));
        chk("sb_carry", 32'(bus.carry), 32'(mon_e.c));
        chk("sb_zero",  32'(bus.zero),  32'(mon_e.z));
        chk("sb_neg",   32'(bus.neg),   32'(mon_e.n));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int bcnt;
    logic [2:0] ro;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs = '{
      '{3'd0, 8'd200, 8'd100, 8'h2C, 1'b1},
      '{3'd1, 8'd5,   8'd5,   8'h00, 1'b0},
      '{3'd1, 8'd3,   8'd5,   8'hFE, 1'b1},
      '{3'd4, 8'h81,  8'd1,   8'h02, 1'b1},
      '{3'd5, 8'h81,  8'd8,   8'h00, 1'b0},
      '{3'd5, 8'h81,  8'd0,   8'h81, 1'b0},
      '{3'd5, 8'h81,  8'd1,   8'h40, 1'b1},
      '{3'd4, 8'h81,  8'd7,   8'h80, 1'b0},
      '{3'd2, 8'hF0,  8'h3C,  8'h30, 1'b0},
      '{3'd7, 8'd5,   8'd3,   8'h00, 1'b0}
    };

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.op        = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out",      32'(bus.out),       32'd0);
    chk("rst_zero",     32'(bus.zero),      32'd0);
    chk("rst_carry",    32'(bus.carry),     32'd0);
    chk("rst_neg",      32'(bus.neg),       32'd0);
    chk("rst_valid",    32'(bus.out_valid), 32'd0);
    chk("rst_busy",     32'(bus.busy),      32'd0);
    chk("rst_in_ready", 32'(bus.in_ready),  32'd1);

    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, mk(vecs[i].o, vecs[i].c));
      chk($sformatf("v%0d_lat1", i), 32'(bus.out_valid), 32'd1);
    end

    send(3'd6, 8'd13, 8'd11, mk(MUL_EN ? 8'h8F : 8'h00, 1'b0));
    cnt  = 0;
    bcnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      bcnt += int'(bus.busy);
      @(posedge clk); #1;
      cnt++;
    end
    chk("mul_edges",      32'(cnt),      MUL_EN ? 32'd8 : 32'd0);
    chk("mul_busy_cycles", 32'(bcnt),    MUL_EN ? 32'd8 : 32'd0);
    chk("mul_busy_after", 32'(bus.busy), 32'd0);
    chk("mul_out",        32'(bus.out),  MUL_EN ? 32'h8F : 32'h00);

    send(3'd6, 8'd20, 8'd20, mk(MUL_EN ? 8'h90 : 8'h00, MUL_EN));

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = (ro == 3'd4 || ro == 3'd5) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      send(ro, ra, rb, model(ro, ra, rb));
    end

    cnt = 0;
    while ((sb.size() != 0 || bus.out_valid) && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("drain1", 32'(sb.size()), 32'd0);

    bus.out_ready = 1'b0;
    send(3'd3, 8'hF0, 8'hFF, mk(8'h0F, 1'b0));
    bus.in_valid = 1'b1;
    bus.op  = 3'd0;
    bus.in1 = 8'd7;
    bus.in2 = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_hold",  32'(bus.out),       32'h0F);
      chk("bp_valid",     32'(bus.out_valid), 32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_join_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    sb.push_back(mk(8'd16, 1'b0));
    bus.in_valid = 1'b0;
    chk("bp_add_out",   32'(bus.out),       32'd16);
    chk("bp_add_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;

`ifdef ALU_MUL_EN
    send(3'd6, 8'd3, 8'd5, mk(8'd15, 1'b0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
`else
    bus.out_ready = 1'b0;
    send(3'd0, 8'h40, 8'h01, mk(8'h41, 1'b0));
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("arst_valid",    32'(bus.out_valid), 32'd0);
    chk("arst_busy",     32'(bus.busy),      32'd0);
    chk("arst_out",      32'(bus.out),       32'd0);
    chk("arst_in_ready", 32'(bus.in_ready),  32'd1);
    sb.delete();
    #4;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    send(3'd0, 8'd1, 8'd1, mk(8'd2, 1'b0));
    chk("post_rst_add", 32'(bus.out), 32'd2);

    cnt = 0;
    while (sb.size() != 0 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("drain2", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
